branch_predict_buffer: RTL and testbench
========================================

BRANCH_PREDICT_BUFFER -- requirements
Module: branch_predict_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of PC, tag and target fields.
REQ-002 SHALL have parameter LINE_NUM, default 16: entry count; legal values are powers of two, 2..64.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1: state-update enable; when low, no state changes except by rst.
REQ-006 SHALL have port flush, input, 1: invalidate all entries.
REQ-007 SHALL have port lookup_pc, input, DATA_WIDTH: fetch-stage PC to predict.
REQ-008 SHALL have port lookup_hit, output, 1: a valid entry matches lookup_pc.
REQ-009 SHALL have port lookup_taken, output, 1: predicted direction.
REQ-010 SHALL have port lookup_target, output, DATA_WIDTH: predicted target.
REQ-011 SHALL have port upd_valid, input, 1: resolved branch present this cycle.
REQ-012 SHALL have port upd_pc, input, DATA_WIDTH: resolved branch PC.
REQ-013 SHALL have port upd_target, input, DATA_WIDTH: resolved target.
REQ-014 SHALL have port upd_taken, input, 1: resolved direction.

Function
REQ-015 SHALL implement a fully associative table; each entry holds a valid bit, a full-width tag, a target and a 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-016 SHALL produce lookup outputs combinationally (zero latency); on multiple matches, the lowest index wins.
REQ-017 SHALL, on lookup hit, drive lookup_taken = counter[1] and lookup_target = stored target; on miss, drive lookup_hit=0, lookup_taken=0, lookup_target=0.
REQ-018 SHALL, on update hit (en & upd_valid), saturate-increment the counter if upd_taken and saturate-decrement it otherwise, with no wrap past 11 or 00.
REQ-019 SHALL, on update hit with upd_taken=1, overwrite the target with upd_target; with upd_taken=0, leave the target unchanged.
REQ-020 SHALL, on update miss with upd_taken=1, allocate a victim: set valid=1, tag=upd_pc, target=upd_target, counter=10.
REQ-021 SHALL NOT allocate on update miss with upd_taken=0.
REQ-022 SHALL choose as victim the lowest-index invalid entry; if all entries are valid, the replacement policy (REQ-030/031) chooses.
REQ-023 SHALL have no bypass: lookup and update in the same cycle (including the same PC) see pre-edge state; the effect is visible the next cycle.
REQ-024 SHALL, when flush=1 and en=1, clear all valid bits; flush has priority and suppresses that cycle's update; replacement state is unchanged.

Reset
REQ-025 SHALL, when rst=1, clear all valid bits, set all counters to 10 and all tags/targets to 0, and reset replacement state per REQ-030/031; rst overrides en, flush and upd_valid.
REQ-026 SHALL drive lookup_hit=0, lookup_taken=0 and lookup_target=0 the cycle after reset, for any lookup_pc.
REQ-027 SHALL, if rst is asserted mid-operation, abandon any in-flight update that cycle.

Configuration
REQ-028 SHALL use the macro BTB_LRU_EN to select the replacement policy.
REQ-029 SHALL use clog2(LINE_NUM)-bit replacement state in both modes.
REQ-030 SHALL, when BTB_LRU_EN is defined, implement true LRU: per-entry age, reset age[i]=i; on update hit or allocation, the touched entry gets age 0, entries younger than it increment, and the rest hold; the victim is the entry with age LINE_NUM-1.
REQ-031 SHALL, when BTB_LRU_EN is undefined, implement round-robin: pointer reset to 0, victim = pointer; the pointer increments (wrapping LINE_NUM-1 -> 0) only on allocations that evict a valid entry.

Verification
REQ-032 Bench SHALL check: reset, then lookup_pc=0x100 -> hit=0, taken=0, target=0.
REQ-033 Bench SHALL check: update pc=0x100, target=0x200, taken=1; next cycle lookup 0x100 -> hit=1, taken=1, target=0x200; same-cycle lookup -> hit=0.
REQ-034 Bench SHALL check: 3 not-taken updates to 0x100 -> counter 10->01->00->00; lookup taken=0, target still 0x200; then 2 taken updates -> taken=1.
REQ-035 Bench SHALL check: LINE_NUM=4, allocate 0x10,0x20,0x30,0x40, update-hit 0x10, allocate 0x50 -> LRU build evicts 0x20, round-robin build evicts 0x10.
REQ-036 Bench SHALL check: flush=1 with a concurrent update to 0x60 -> all lookups miss next cycle and 0x60 is not allocated.
REQ-037 Bench SHALL check: en=0 with upd_valid=1 taken -> no allocation; not-taken miss update -> no allocation.

Source files
------------

// File: rtl/branch_predict_buffer.sv
// Fully associative branch target buffer with 2-bit saturating direction counters.
// Replacement policy: round-robin by default, true LRU when BTB_LRU_EN is defined.
module branch_predict_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_NUM   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] lookup_pc,
    output logic                  lookup_hit,
    output logic                  lookup_taken,
    output logic [DATA_WIDTH-1:0] lookup_target,
    input  logic                  upd_valid,
    input  logic [DATA_WIDTH-1:0] upd_pc,
    input  logic [DATA_WIDTH-1:0] upd_target,
    input  logic                  upd_taken
);
    localparam int IDX_W = $clog2(LINE_NUM);

    logic                  valid_q  [LINE_NUM];
    logic [DATA_WIDTH-1:0] tag_q    [LINE_NUM];
    logic [DATA_WIDTH-1:0] target_q [LINE_NUM];
    logic [1:0]            ctr_q    [LINE_NUM];

    logic [LINE_NUM-1:0] valid_vec;
    logic [LINE_NUM-1:0] lookup_match;
    logic [LINE_NUM-1:0] upd_match;

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] inv_idx;
    logic [IDX_W-1:0] repl_victim;
    logic [IDX_W-1:0] victim_idx;
    logic [IDX_W-1:0] touch_idx;

    logic upd_hit;
    logic inv_any;
    logic do_upd;
    logic do_hit;
    logic do_alloc;
    logic do_touch;

    genvar gi;
    generate
        for (gi = 0; gi < LINE_NUM; gi++) begin : g_match
            assign valid_vec[gi]    = valid_q[gi];
            assign lookup_match[gi] = valid_q[gi] && (tag_q[gi] == lookup_pc);
            assign upd_match[gi]    = valid_q[gi] && (tag_q[gi] == upd_pc);
        end
    endgenerate

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        lookup_idx = '0;
        upd_idx    = '0;
        inv_idx    = '0;
        for (int i = LINE_NUM - 1; i >= 0; i--) begin
            if (lookup_match[i]) lookup_idx = IDX_W'(i);
            if (upd_match[i])    upd_idx    = IDX_W'(i);
            if (!valid_vec[i])   inv_idx    = IDX_W'(i);
        end
    end

    assign upd_hit = |upd_match;
    assign inv_any = ~&valid_vec;

    always_comb begin
        lookup_hit    = |lookup_match;
        lookup_taken  = 1'b0;
        lookup_target = '0;
        if (lookup_hit) begin
            lookup_taken  = ctr_q[lookup_idx][1];
            lookup_target = target_q[lookup_idx];
        end
    end

    // Flush wins over the update in the same cycle.
    assign do_upd     = en && !flush && upd_valid;
    assign do_hit     = do_upd && upd_hit;
    assign do_alloc   = do_upd && !upd_hit && upd_taken;
    assign do_touch   = do_hit || do_alloc;
    assign victim_idx = inv_any ? inv_idx : repl_victim;
    assign touch_idx  = upd_hit ? upd_idx : victim_idx;

    generate
        for (gi = 0; gi < LINE_NUM; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q[gi]  <= 1'b0;
                    tag_q[gi]    <= '0;
                    target_q[gi] <= '0;
                    ctr_q[gi]    <= 2'b10;
                end else if (en && flush) begin
                    valid_q[gi] <= 1'b0;
                end else if (do_hit && (upd_idx == IDX_W'(gi))) begin
                    if (upd_taken) begin
                        target_q[gi] <= upd_target;
                        if (ctr_q[gi] != 2'b11) ctr_q[gi] <= ctr_q[gi] + 2'b01;
                    end else begin
                        if (ctr_q[gi] != 2'b00) ctr_q[gi] <= ctr_q[gi] - 2'b01;
                    end
                end else if (do_alloc && (victim_idx == IDX_W'(gi))) begin
                    valid_q[gi]  <= 1'b1;
                    tag_q[gi]    <= upd_pc;
                    target_q[gi] <= upd_target;
                    ctr_q[gi]    <= 2'b10;
                end
            end
        end
    endgenerate

`ifdef BTB_LRU_EN
    // Ages form a permutation of 0..LINE_NUM-1; the oldest entry is the victim.
    logic [IDX_W-1:0] age_q [LINE_NUM];

    always_comb begin
        repl_victim = '0;
        for (int i = 0; i < LINE_NUM; i++) begin
            if (age_q[i] == IDX_W'(LINE_NUM - 1)) repl_victim = IDX_W'(i);
        end
    end

    generate
        for (gi = 0; gi < LINE_NUM; gi++) begin : g_age
            always_ff @(posedge clk) begin
                if (rst) begin
                    age_q[gi] <= IDX_W'(gi);
                end else if (do_touch) begin
                    if (touch_idx == IDX_W'(gi)) begin
                        age_q[gi] <= '0;
                    end else if (age_q[gi] < age_q[touch_idx]) begin
                        age_q[gi] <= age_q[gi] + IDX_W'(1);
                    end
                end
            end
        end
    endgenerate
`else
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    assign repl_victim = ptr_q;

    // Filling an empty slot does not advance the pointer; only real evictions do.
    always_comb begin
        ptr_d = ptr_q;
        if (do_alloc && !inv_any) ptr_d = ptr_q + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    logic unused_touch;
    assign unused_touch = do_touch ^ (|touch_idx);
`endif

endmodule

// File: tb/tb_branch_predict_buffer.sv
// Directed bench for branch_predict_buffer (LINE_NUM=4); build with BTB_LRU_EN for the LRU policy.
module tb_branch_predict_buffer;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          flush;
    logic [DW-1:0] lookup_pc;
    logic          lookup_hit;
    logic          lookup_taken;
    logic [DW-1:0] lookup_target;
    logic          upd_valid;
    logic [DW-1:0] upd_pc;
    logic [DW-1:0] upd_target;
    logic          upd_taken;

    int errors = 0;
    int checks = 0;

    branch_predict_buffer #(.DATA_WIDTH(DW), .LINE_NUM(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .flush         (flush),
        .lookup_pc     (lookup_pc),
        .lookup_hit    (lookup_hit),
        .lookup_taken  (lookup_taken),
        .lookup_target (lookup_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          flush;
        logic          uv;
        logic          tk;
        logic [DW-1:0] pc;
        logic [DW-1:0] tgt;
        logic [DW-1:0] lpc;
        logic          ehit;
        logic          etk;
        logic [DW-1:0] etgt;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

`ifdef BTB_LRU_EN
    localparam logic [DW-1:0] EVICT1 = 32'h20;
    localparam logic [DW-1:0] EVICT2 = 32'h30;
`else
    localparam logic [DW-1:0] EVICT1 = 32'h10;
    localparam logic [DW-1:0] EVICT2 = 32'h20;
`endif

    task automatic chk(input string name, input logic [DW+1:0] got, input logic [DW+1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got hit/taken/target=%b/%b/%h expected %b/%b/%h", name,
                     got[DW+1], got[DW], got[DW-1:0], exp[DW+1], exp[DW], exp[DW-1:0]);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; the next rising edge consumes them.
    task automatic drive(input logic e, input logic f, input logic uv, input logic [DW-1:0] pc,
                         input logic [DW-1:0] tgt, input logic tk, input logic [DW-1:0] lpc);
        @(negedge clk);
        rst = 1'b0; en = e; flush = f; upd_valid = uv;
        upd_pc = pc; upd_target = tgt; upd_taken = tk; lookup_pc = lpc;
        #1;
    endtask

    task automatic upd(input logic [DW-1:0] pc, input logic [DW-1:0] tgt, input logic tk);
        drive(1'b1, 1'b0, 1'b1, pc, tgt, tk, 32'h0);
        $display("upd pc=%h tgt=%h taken=%b", pc, tgt, tk);
    endtask

    task automatic look(input string name, input logic [DW-1:0] pc, input logic eh,
                        input logic [DW-1:0] et);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, pc);
        $display("look %s pc=%h hit=%b taken=%b target=%h", name, pc, lookup_hit, lookup_taken,
                 lookup_target);
        chk(name, {lookup_hit, lookup_taken, lookup_target}, {eh, eh, et});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; flush = 1'b0; upd_valid = 1'b0;
        upd_pc = '0; upd_target = '0; upd_taken = 1'b0; lookup_pc = '0;
        @(negedge clk);
        rst = 1'b0;
        $display("reset");
    endtask

    initial begin
        //           en flush uv tk  upd_pc        upd_tgt       lookup_pc     hit tk target
        vecs[0]  = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h100,      0, 0, 32'h0};
        vecs[1]  = '{1, 0, 1, 1, 32'h100,      32'h200,      32'h100,      0, 0, 32'h0};
        vecs[2]  = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h100,      1, 1, 32'h200};
        vecs[3]  = '{1, 0, 1, 0, 32'h100,      32'h999,      32'h100,      1, 1, 32'h200};
        vecs[4]  = '{1, 0, 1, 0, 32'h100,      32'h999,      32'h100,      1, 0, 32'h200};
        vecs[5]  = '{1, 0, 1, 0, 32'h100,      32'h999,      32'h100,      1, 0, 32'h200};
        vecs[6]  = '{1, 0, 1, 1, 32'h100,      32'h280,      32'h100,      1, 0, 32'h200};
        vecs[7]  = '{1, 0, 1, 1, 32'h100,      32'h280,      32'h100,      1, 0, 32'h280};
        vecs[8]  = '{1, 0, 1, 1, 32'h100,      32'h280,      32'h100,      1, 1, 32'h280};
        vecs[9]  = '{1, 0, 1, 1, 32'h100,      32'h2C0,      32'h100,      1, 1, 32'h280};
        vecs[10] = '{1, 0, 1, 0, 32'h100,      32'h999,      32'h100,      1, 1, 32'h2C0};
        vecs[11] = '{1, 0, 1, 0, 32'h100,      32'h999,      32'h100,      1, 1, 32'h2C0};
        vecs[12] = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h100,      1, 0, 32'h2C0};
        vecs[13] = '{0, 0, 1, 1, 32'h500,      32'h5A0,      32'h100,      1, 0, 32'h2C0};
        vecs[14] = '{0, 0, 1, 1, 32'h100,      32'h777,      32'h500,      0, 0, 32'h0};
        vecs[15] = '{1, 0, 1, 0, 32'h600,      32'h6A0,      32'h100,      1, 0, 32'h2C0};
        vecs[16] = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h600,      0, 0, 32'h0};
        vecs[17] = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h500,      0, 0, 32'h0};
        vecs[18] = '{1, 0, 0, 0, 32'h0,        32'h0,        32'h80000100, 0, 0, 32'h0};

        do_reset();
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].en, vecs[i].flush, vecs[i].uv, vecs[i].pc, vecs[i].tgt, vecs[i].tk,
                  vecs[i].lpc);
            $display("vec%0d en=%b uv=%b tk=%b upc=%h lpc=%h -> hit=%b taken=%b target=%h", i,
                     vecs[i].en, vecs[i].uv, vecs[i].tk, vecs[i].pc, vecs[i].lpc, lookup_hit,
                     lookup_taken, lookup_target);
            chk($sformatf("vec%0d", i), {lookup_hit, lookup_taken, lookup_target},
                {vecs[i].ehit, vecs[i].etk, vecs[i].etgt});
        end

        // Replacement: fill all four ways, touch 0x10, then force two evictions.
        do_reset();
        upd(32'h10, 32'h1010, 1'b1);
        upd(32'h20, 32'h1020, 1'b1);
        upd(32'h30, 32'h1030, 1'b1);
        upd(32'h40, 32'h1040, 1'b1);
        upd(32'h10, 32'h1011, 1'b1);
        upd(32'h50, 32'h1050, 1'b1);
        look("repl_new50", 32'h50, 1'b1, 32'h1050);
        look("repl_evict1", EVICT1, 1'b0, 32'h0);
        look("repl_keep40", 32'h40, 1'b1, 32'h1040);
        upd(32'h58, 32'h1058, 1'b1);
        look("repl_new58", 32'h58, 1'b1, 32'h1058);
        look("repl_evict2", EVICT2, 1'b0, 32'h0);
        look("repl_keep50", 32'h50, 1'b1, 32'h1050);

        // Flush is ignored without en, and suppresses a concurrent allocation with en.
        drive(1'b0, 1'b1, 1'b1, 32'h60, 32'h1060, 1'b1, 32'h0);
        look("flush_noen_keep", 32'h40, 1'b1, 32'h1040);
        drive(1'b1, 1'b1, 1'b1, 32'h60, 32'h1060, 1'b1, 32'h40);
        chk("flush_same_cycle", {lookup_hit, lookup_taken, lookup_target}, {2'b11, 32'h1040});
        look("flush_miss40", 32'h40, 1'b0, 32'h0);
        look("flush_miss50", 32'h50, 1'b0, 32'h0);
        look("flush_miss58", 32'h58, 1'b0, 32'h0);
        look("flush_no60", 32'h60, 1'b0, 32'h0);

        // Reset mid-operation abandons the concurrent update and clears everything.
        upd(32'h70, 32'h1070, 1'b1);
        look("pre_rst70", 32'h70, 1'b1, 32'h1070);
        @(negedge clk);
        rst = 1'b1; en = 1'b1; flush = 1'b0; upd_valid = 1'b1;
        upd_pc = 32'h90; upd_target = 32'h1090; upd_taken = 1'b1;
        look("rst_miss70", 32'h70, 1'b0, 32'h0);
        look("rst_miss90", 32'h90, 1'b0, 32'h0);
        look("rst_miss0", 32'h0, 1'b0, 32'h0);
        upd(32'h90, 32'h1091, 1'b1);
        look("rst_realloc90", 32'h90, 1'b1, 32'h1091);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
